fifo_generator: RTL and testbench
=================================

# fifo_generator

Single-clock, width-converting FIFO: bytes go in, 32-bit words come out. It sits between the camera pixel path (upper 8 bits of each 10-bit pixel) and the PC block-transfer pipe. Four consecutive bytes are packed into one read word. `prog_full` signals that a full transfer block is ready to read.

## Interface
Parameters:
- `WR_DEPTH`, default 4096: capacity in bytes. Must be a power of two and a multiple of 4.
- `PROG_FULL_THRESH`, default 512: read-word count at or above which `prog_full` asserts. Range 1 to WR_DEPTH/4.

Ports:
- `clk`, in, 1: single clock for all logic. All flags and data are registered on its rising edge.
- `srst`, in, 1: synchronous reset, active-high, sampled on the `clk` rising edge.
- `din`, in, 8: write byte.
- `wr_en`, in, 1: write request.
- `rd_en`, in, 1: read request.
- `dout`, out, 32: read word.
- `full`, out, 1: no room for another byte.
- `empty`, out, 1: no complete 32-bit word available.
- `prog_full`, out, 1: stored complete words are at or above `PROG_FULL_THRESH`.
- `rd_data_count`, out, log2(WR_DEPTH/4)+1: number of complete words stored. Present only with `FIFO_DATA_COUNT_EN`.

## Operation
- Storage is a WR_DEPTH x 8 circular buffer.
- Write pointer and read pointer each carry one extra wrap bit. The read pointer advances by 4 bytes per read.
- Byte count = wr_ptr − rd_ptr. Word count = byte count >> 2.
- Packing order: the first byte written into a word goes to `dout[31:24]`, the fourth byte to `dout[7:0]`.
- Accepted write: `wr_en`=1 and `full`=0. The byte is stored and wr_ptr increments. A write while full is dropped; state is unchanged.
- Accepted read: `rd_en`=1 and `empty`=0. `dout` loads the 4 bytes at rd_ptr and rd_ptr advances by 4. A read while empty is ignored and `dout` holds its value.
- Simultaneous accepted read and write: both take effect. Byte count changes by +1−4 = −3.
- `full` = (byte count == WR_DEPTH).
- `empty` = (byte count < 4). A partial word of 1–3 bytes is not readable and stays held until its 4th byte arrives.
- `prog_full` = (word count ≥ PROG_FULL_THRESH). It deasserts as soon as the word count drops below the threshold. There is no hysteresis.
- Pointers wrap modulo 2·WR_DEPTH. Buffer addressing uses the low log2(WR_DEPTH) bits.
- Reset (`srst`=1 at an edge):
  - pointers go to 0, `dout`=0, `empty`=1, `full`=0, `prog_full`=0, `rd_data_count`=0;
  - any partial word is discarded;
  - `wr_en`/`rd_en` in the same cycle are ignored;
  - reset may be applied mid-operation with the same result.

## Timing
- Write latency: a byte written at edge N updates the counts and flags at edge N. `empty` falls at the edge that accepts the 4th byte of a word.
- Read latency: one cycle. A read accepted at edge N presents the new `dout` right after edge N.
- All flags are registered and consistent with the pointer state after each edge. Nothing is combinationally derived from `wr_en`/`rd_en`.
- `full` rises at the edge accepting byte WR_DEPTH. It falls at the edge of the next accepted read.
- No first-word-fall-through: `dout` is never updated without an accepted read.

## Configuration
- `FIFO_DATA_COUNT_EN` defined:
  - port `rd_data_count` exists;
  - it is registered and equals the word count after each edge;
  - a completely full buffer reports WR_DEPTH/4, which is why the port is log2(WR_DEPTH/4)+1 bits wide.
- `FIFO_DATA_COUNT_EN` undefined: the port is absent and all other behaviour is identical.

## Test plan
- Pack order:
  - stimulus: reset, write 0x11, 0x22, 0x33 → `empty` stays 1; write 0x44 → `empty`=0;
  - stimulus: one `rd_en` pulse → response: `dout`=0x11223344 after that edge, `empty`=1.
- Fill to capacity:
  - stimulus: write 4096 bytes with no reads → response: `full`=1 at the edge of byte 4096, byte 4097 is dropped;
  - stimulus: one read → response: `full`=0, `rd_data_count`=1023.
- prog_full threshold:
  - stimulus: write 2044 bytes (511 words) → response: `prog_full`=0;
  - stimulus: write 4 more bytes → response: `prog_full`=1;
  - stimulus: one read → response: `prog_full`=0.
- Empty read and wrap-around:
  - stimulus: `rd_en` while empty → response: `dout` unchanged;
  - stimulus: stream 3×WR_DEPTH incrementing bytes with interleaved reads → response: every word matches the packed byte sequence across the pointer wrap.
- Simultaneous read/write with 8 bytes stored:
  - stimulus: 4 cycles of both `wr_en` and `rd_en` → response: reads are accepted only while `empty`=0, and byte order is preserved.
- Mid-operation reset:
  - stimulus: 6 bytes written, then `srst` pulsed for one cycle together with `wr_en`=1 → response: `empty`=1, `dout`=0, `rd_data_count`=0, and the next 4 writes form the first word.

Source files
------------

// File: rtl/fifo_generator.sv
// rtl/fifo_generator.sv - byte-in / 32-bit-word-out single-clock FIFO
//
// Purpose: packs four consecutive written bytes into one read word. The
// first byte of a word lands in dout[31:24] and the fourth in dout[7:0].
// Optional feature macro: FIFO_DATA_COUNT_EN adds the rd_data_count port.
//
// Ports:
//   clk           - single clock, all state registered on rising edge
//   srst          - synchronous active-high reset
//   din           - write byte
//   wr_en         - write request (dropped while full)
//   rd_en         - read request (ignored while empty)
//   dout          - read word, updated only by an accepted read
//   full          - WR_DEPTH bytes stored
//   empty         - fewer than 4 bytes stored (no complete word)
//   prog_full     - complete words stored >= PROG_FULL_THRESH
//   rd_data_count - complete words stored (FIFO_DATA_COUNT_EN only)
module fifo_generator #(
    parameter int WR_DEPTH         = 4096,
    parameter int PROG_FULL_THRESH = 512
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [7:0]  din,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty,
    output logic        prog_full
`ifdef FIFO_DATA_COUNT_EN
    ,
    output logic [$clog2(WR_DEPTH/4):0] rd_data_count
`endif
);

    localparam int AW = $clog2(WR_DEPTH);
    localparam int PW = AW + 1;  // pointer width including wrap bit
    localparam int CW = AW - 1;  // word count width, holds WR_DEPTH/4

    logic [7:0]    mem_q [WR_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] byte_cnt_d;
    logic [CW-1:0] word_cnt_d;
    logic [31:0]   dout_q, dout_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          prog_full_q, prog_full_d;
    logic          wr_acc, rd_acc;
    logic [AW-1:0] wr_addr, rd_base;

    always_comb begin
        wr_acc  = wr_en && !full_q;
        rd_acc  = rd_en && !empty_q;
        wr_addr = wr_ptr_q[AW-1:0];
        // rd_ptr only moves in steps of 4 from 0, so the word is 4-aligned
        rd_base = {rd_ptr_q[AW-1:2], 2'b00};

        wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PW'(4) : rd_ptr_q;

        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = {mem_q[rd_base], mem_q[rd_base | AW'(1)],
                      mem_q[rd_base | AW'(2)], mem_q[rd_base | AW'(3)]};
        end

        // Flags are computed from the next pointers so that the registered
        // flags describe the state right after the edge.
        byte_cnt_d  = wr_ptr_d - rd_ptr_d;
        word_cnt_d  = byte_cnt_d[PW-1:2];
        full_d      = (byte_cnt_d == PW'(WR_DEPTH));
        empty_d     = (byte_cnt_d < PW'(4));
        prog_full_d = (word_cnt_d >= CW'(PROG_FULL_THRESH));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dout_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            prog_full_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dout_q      <= dout_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            prog_full_q <= prog_full_d;
        end
    end

    // Storage has no reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!srst && wr_acc) begin
            mem_q[wr_addr] <= din;
        end
    end

    assign dout      = dout_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign prog_full = prog_full_q;

`ifdef FIFO_DATA_COUNT_EN
    logic [CW-1:0] rd_data_count_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_count_q <= '0;
        end else begin
            rd_data_count_q <= word_cnt_d;
        end
    end

    assign rd_data_count = rd_data_count_q;
`endif

endmodule

// File: tb/tb_fifo_generator.sv
// tb/tb_fifo_generator.sv - self-checking bench for fifo_generator
module tb_fifo_generator;

    localparam int DEPTH  = 4096;
    localparam int THRESH = 512;

    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  din;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic        prog_full;
`ifdef FIFO_DATA_COUNT_EN
    logic [$clog2(DEPTH/4):0] rd_data_count;
`endif

    fifo_generator #(
        .WR_DEPTH         (DEPTH),
        .PROG_FULL_THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .prog_full (prog_full)
`ifdef FIFO_DATA_COUNT_EN
        ,
        .rd_data_count (rd_data_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the stored bytes in arrival order plus the last word read.
    logic [7:0]  q [$];
    logic [31:0] exp_dout;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dout", dout, exp_dout);
        chk("empty", {31'd0, empty}, {31'd0, q.size() < 4});
        chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
        chk("prog_full", {31'd0, prog_full}, {31'd0, (q.size() / 4) >= THRESH});
`ifdef FIFO_DATA_COUNT_EN
        chk("rd_data_count", 32'(rd_data_count), 32'(q.size() / 4));
`endif
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rst);
        logic aw, ar;
        srst  = rst;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_dout = 32'd0;
        end else begin
            aw = w && (q.size() < DEPTH);
            ar = r && (q.size() >= 4);
            if (ar) begin
                exp_dout = {q[0], q[1], q[2], q[3]};
                repeat (4) void'(q.pop_front());
            end
            if (aw) q.push_back(d);
        end
        check_all();
    endtask

    int nb;
    int budget;
    logic [31:0] held;

    initial begin
        exp_dout = 32'd0;
        srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'd0;

        // Reset state and pack order
        step(1'b1, 1'b1, 8'h5a, 1'b1);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        chk("partial_empty", {31'd0, empty}, 32'd1);
        step(1'b1, 1'b0, 8'h44, 1'b0);
        chk("word_ready", {31'd0, empty}, 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pack_order", dout, 32'h11223344);

        // Read while empty holds dout
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("empty_read_hold", dout, 32'h11223344);

        // Fill to capacity, overflow byte dropped, then one read
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        chk("full_at_capacity", {31'd0, full}, 32'd1);
        step(1'b1, 1'b0, 8'haa, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("full_after_read", {31'd0, full}, 32'd0);
        chk("first_word_after_fill", dout, 32'h00010203);

        // prog_full threshold
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < (THRESH - 1) * 4; i++) step(1'b1, 1'b0, 8'(i * 7), 1'b0);
        chk("below_thresh", {31'd0, prog_full}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        chk("at_thresh", {31'd0, prog_full}, 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("thresh_drop", {31'd0, prog_full}, 32'd0);

        // Randomized streaming across pointer wrap
        step(1'b0, 1'b0, 8'h00, 1'b1);
        nb = 0;
        budget = 0;
        while (nb < 3 * DEPTH && budget < 60000) begin
            logic w;
            w = ($urandom_range(0, 3) != 0);
            if (w && q.size() < DEPTH) begin
                step(1'b1, 1'($urandom_range(0, 1)), 8'(nb), 1'b0);
                nb++;
            end else begin
                step(w, 1'($urandom_range(0, 1)), 8'(nb), 1'b0);
            end
            budget++;
        end
        chk("stream_completed", 32'(nb), 32'(3 * DEPTH));
        budget = 0;
        while (q.size() >= 4 && budget < 2000) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            budget++;
        end
        chk("drain_completed", {31'd0, q.size() < 4}, 32'd1);

        // Simultaneous read/write with 8 bytes stored
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'(8'hc0 + i), 1'b0);
            if (i == 0) chk("rw_word0", dout, 32'h80818283);
            if (i == 1) chk("rw_word1", dout, 32'h84858687);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rw_word2", dout, 32'hc0c1c2c3);

        // Mid-operation reset with a concurrent write
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        step(1'b1, 1'b0, 8'hee, 1'b1);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_dout", dout, 32'd0);
        step(1'b1, 1'b0, 8'ha1, 1'b0);
        step(1'b1, 1'b0, 8'ha2, 1'b0);
        step(1'b1, 1'b0, 8'ha3, 1'b0);
        step(1'b1, 1'b0, 8'ha4, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        held = dout;
        chk("midrst_first_word", held, 32'ha1a2a3a4);

        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
